io_bus_responder: RTL and testbench

// - Bus-side I/O peripheral answering the CPU's 16-bit bidirectional data-bus transceiver.
// - Latches CPU writes into an output port with a valid/ready handshake to the external device.
// - Buffers device input words in a small FIFO that the CPU drains by reading.
// - Sits between the CPU datapath bus and the off-core I/O device.

---
 rtl/io_bus_responder_pkg.sv | 31 +++
 rtl/io_bus_responder_fifo.sv | 61 ++++++
 rtl/io_bus_responder.sv | 175 +++++++++++++++++
 tb/tb_io_bus_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/io_bus_responder_pkg.sv
// Shared definitions for the io_bus_responder peripheral: register map,
// STATUS/CTRL bit positions and the output-port handshake state type.
package io_bus_responder_pkg;

  // Register select values on io_addr
  localparam logic [1:0] IO_ADDR_OUT    = 2'd0;
  localparam logic [1:0] IO_ADDR_IN     = 2'd1;
  localparam logic [1:0] IO_ADDR_STATUS = 2'd2;
  localparam logic [1:0] IO_ADDR_CTRL   = 2'd3;

  // STATUS register bit positions (count occupies [ST_COUNT_LSB +: AW+1])
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OUT_VALID = 2;
  localparam int ST_OVERRUN   = 3;
  localparam int ST_UNDERFLOW = 4;
  localparam int ST_IRQ_EN    = 5;
  localparam int ST_COUNT_LSB = 8;

  // CTRL register bit positions
  localparam int CTRL_CLEAR  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  // Output-port handshake state
  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_BUSY = 1'b1
  } out_state_e;

endpackage

// File: rtl/io_bus_responder_fifo.sv
// Synchronous input FIFO for io_bus_responder. DEPTH must equal 2**AW so the
// pointers wrap naturally. Flush empties the FIFO and overrides a same-cycle
// push or pop. Push when full and pop when empty are ignored.
module io_bus_responder_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  // Storage write at the tail
  // NOTE: the data array has no reset; count/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointer and occupancy tracking; flush returns to the reset state
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/io_bus_responder.sv
// io_bus_responder: CPU bus-side I/O peripheral. Registers: OUT (write-latched
// output word with valid/ready handshake), IN (input FIFO head, popped on read),
// STATUS (read-only flags and FIFO count), CTRL (sticky clear, irq enable, flush).
// Optional feature macro IO_RESP_IRQ_EN: when defined, irq_en is stored and irq is
// a registered irq_en & !empty; otherwise irq is tied low and irq_en reads 0.
module io_bus_responder
  import io_bus_responder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       io_addr,
  input  logic             io_we,
  input  logic             io_re,
  inout  wire  [WIDTH-1:0] bus,
  output logic             bus_oe,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             irq
);

  out_state_e       out_state_q;
  logic [WIDTH-1:0] out_data_q;
  logic             overrun_q, overrun_d;
  logic             underflow_q, underflow_d;
  logic             irq_en;
  logic [WIDTH-1:0] rdata;

  logic             rd_cyc;
  logic             wr_out, wr_ctrl, rd_in;
  logic             sticky_clear, overrun_set, underflow_set;

  logic             fifo_push, fifo_pop, fifo_flush;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic [AW:0]      fifo_count;

  // A simultaneous write strobe takes the cycle: no drive, no pop
  assign rd_cyc  = io_re & ~io_we;
  assign bus_oe  = rd_cyc;
  assign bus     = bus_oe ? rdata : 'z;

  assign wr_out  = io_we & (io_addr == IO_ADDR_OUT);
  assign wr_ctrl = io_we & (io_addr == IO_ADDR_CTRL);
  assign rd_in   = rd_cyc & (io_addr == IO_ADDR_IN);

  assign out_valid = (out_state_q == OUT_BUSY);
  assign out_data  = out_data_q;
  assign in_ready  = ~fifo_full;

  assign fifo_push  = in_valid & ~fifo_full;
  assign fifo_pop   = rd_in & ~fifo_empty;
  assign fifo_flush = wr_ctrl & bus[CTRL_FLUSH];

  assign sticky_clear  = wr_ctrl & bus[CTRL_CLEAR];
  assign overrun_set   = wr_out & out_valid & ~out_ready;
  assign underflow_set = rd_in & fifo_empty;

  io_bus_responder_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .flush(fifo_flush),
    .wdata(in_data),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // Output-port FSM: load on write when idle; an accept with a same-cycle write reloads
  always_ff @(posedge clk) begin
    if (reset) begin
      out_state_q <= OUT_IDLE;
      out_data_q  <= '0;
    end else begin
      case (out_state_q)
        OUT_IDLE: begin
          if (wr_out) begin
            out_data_q  <= bus;
            out_state_q <= OUT_BUSY;
          end
        end
        OUT_BUSY: begin
          if (out_ready) begin
            if (wr_out) out_data_q  <= bus;
            else        out_state_q <= OUT_IDLE;
          end
        end
        default: out_state_q <= OUT_IDLE;
      endcase
    end
  end

  // Sticky error flags: set by the offending access, cleared through CTRL bit0
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    overrun_d   = overrun_q;
    underflow_d = underflow_q;
    if (sticky_clear) begin
      overrun_d   = 1'b0;
      underflow_d = 1'b0;
    end
    if (overrun_set)   overrun_d   = 1'b1;
    if (underflow_set) underflow_d = 1'b1;
  end

  // Sticky flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overrun_q   <= overrun_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef IO_RESP_IRQ_EN
  logic irq_en_q;
  logic irq_q;

  // Interrupt enable and registered request (lags FIFO occupancy by one edge)
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= bus[CTRL_IRQ_EN];
      irq_q <= irq_en_q & ~fifo_empty;
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = irq_q;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  // Read data mux; valid in the same cycle as the read strobe
  always_comb begin
    rdata = '0;
    case (io_addr)
      IO_ADDR_OUT: rdata = out_data_q;
      IO_ADDR_IN: begin
        if (!fifo_empty) rdata = fifo_rdata;
      end
      IO_ADDR_STATUS: begin
        rdata[ST_EMPTY]              = fifo_empty;
        rdata[ST_FULL]               = fifo_full;
        rdata[ST_OUT_VALID]          = out_valid;
        rdata[ST_OVERRUN]            = overrun_q;
        rdata[ST_UNDERFLOW]          = underflow_q;
        rdata[ST_IRQ_EN]             = irq_en;
        rdata[ST_COUNT_LSB +: AW+1]  = fifo_count;
      end
      IO_ADDR_CTRL: rdata[CTRL_IRQ_EN] = irq_en;
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_io_bus_responder.sv
// Self-checking bench for io_bus_responder: a table of one-cycle bus/device
// vectors with hand-computed pre-edge expectations, plus hand sequences for the
// irq timing and a reset in the middle of an output handshake.
module tb_io_bus_responder;

`ifdef IO_RESP_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [1:0]  io_addr;
  logic        io_we;
  logic        io_re;
  logic [15:0] tb_wd;
  wire  [15:0] bus;
  logic        bus_oe;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  assign bus = io_we ? tb_wd : 'z;

  io_bus_responder #(.WIDTH(16), .DEPTH(4), .AW(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .io_addr  (io_addr),
    .io_we    (io_we),
    .io_re    (io_re),
    .bus      (bus),
    .bus_oe   (bus_oe),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [1:0]  addr;
    logic [15:0] wd;
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic        e_oe;
    logic [15:0] e_bus;
    logic        e_ov;
    logic [15:0] e_od;
    logic        e_ir;
    logic        e_irq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic we, logic re, logic [1:0] addr, logic [15:0] wd,
                               logic iv, logic [15:0] id, logic ordy,
                               logic e_oe, logic [15:0] e_bus, logic e_ov,
                               logic [15:0] e_od, logic e_ir, logic e_irq);
    vec_t v;
    v.we = we; v.re = re; v.addr = addr; v.wd = wd;
    v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_oe = e_oe; v.e_bus = e_bus; v.e_ov = e_ov;
    v.e_od = e_od; v.e_ir = e_ir; v.e_irq = e_irq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check pre-edge outputs mid-cycle, then clock
  task automatic run_vec(input vec_t v, input string tag);
    io_we = v.we; io_re = v.re; io_addr = v.addr; tb_wd = v.wd;
    in_valid = v.iv; in_data = v.id; out_ready = v.ordy;
    #2;
    check({tag, " bus_oe"}, 32'(bus_oe), 32'(v.e_oe));
    if (v.e_oe) check({tag, " bus"}, 32'(bus), 32'(v.e_bus));
    check({tag, " out_valid"}, 32'(out_valid), 32'(v.e_ov));
    check({tag, " out_data"}, 32'(out_data), 32'(v.e_od));
    check({tag, " in_ready"}, 32'(in_ready), 32'(v.e_ir));
    check({tag, " irq"}, 32'(irq), 32'(v.e_irq));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Fields: we re addr wd iv id ordy | oe bus out_valid out_data in_ready irq
    // Output port: load, overrun while busy, accept
    vecs.push_back(mkv(0,1,2,16'h0000, 0,16'h0000,0, 1,16'h0001, 0,16'h0000,1,0)); // STATUS after reset
    vecs.push_back(mkv(1,0,0,16'hA5A5, 0,16'h0000,0, 0,16'h0000, 0,16'h0000,1,0)); // write OUT
    vecs.push_back(mkv(0,0,0,16'h0000, 0,16'h0000,0, 0,16'h0000, 1,16'hA5A5,1,0));
    vecs.push_back(mkv(0,0,0,16'h0000, 0,16'h0000,0, 0,16'h0000, 1,16'hA5A5,1,0));
    vecs.push_back(mkv(1,0,0,16'h1234, 0,16'h0000,0, 0,16'h0000, 1,16'hA5A5,1,0)); // overrun write
    vecs.push_back(mkv(0,1,2,16'h0000, 0,16'h0000,0, 1,16'h000D, 1,16'hA5A5,1,0)); // empty|valid|overrun
    vecs.push_back(mkv(0,0,0,16'h0000, 0,16'h0000,1, 0,16'h0000, 1,16'hA5A5,1,0)); // accept
    vecs.push_back(mkv(0,0,0,16'h0000, 0,16'h0000,0, 0,16'h0000, 0,16'hA5A5,1,0));
    vecs.push_back(mkv(0,1,0,16'h0000, 0,16'h0000,0, 1,16'hA5A5, 0,16'hA5A5,1,0)); // read OUT
    vecs.push_back(mkv(1,0,3,16'h0001, 0,16'h0000,0, 0,16'h0000, 0,16'hA5A5,1,0)); // clear stickies
    // Write in the same cycle as accept: reload, stay busy, no overrun
    vecs.push_back(mkv(1,0,0,16'h1111, 0,16'h0000,0, 0,16'h0000, 0,16'hA5A5,1,0));
    vecs.push_back(mkv(1,0,0,16'h2222, 0,16'h0000,1, 0,16'h0000, 1,16'h1111,1,0));
    vecs.push_back(mkv(0,1,2,16'h0000, 0,16'h0000,0, 1,16'h0005, 1,16'h2222,1,0));
    vecs.push_back(mkv(0,0,0,16'h0000, 0,16'h0000,1, 0,16'h0000, 1,16'h2222,1,0));
    vecs.push_back(mkv(0,0,0,16'h0000, 0,16'h0000,0, 0,16'h0000, 0,16'h2222,1,0));
    // Fill the FIFO, fifth word refused, pop while full with in_valid held
    vecs.push_back(mkv(0,0,0,16'h0000, 1,16'h0001,0, 0,16'h0000, 0,16'h2222,1,0));
    vecs.push_back(mkv(0,0,0,16'h0000, 1,16'h0002,0, 0,16'h0000, 0,16'h2222,1,0));
    vecs.push_back(mkv(0,0,0,16'h0000, 1,16'h0003,0, 0,16'h0000, 0,16'h2222,1,0));
    vecs.push_back(mkv(0,0,0,16'h0000, 1,16'h0004,0, 0,16'h0000, 0,16'h2222,1,0));
    vecs.push_back(mkv(0,1,2,16'h0000, 1,16'h0005,0, 1,16'h0402, 0,16'h2222,0,0)); // full, count 4
    vecs.push_back(mkv(0,1,1,16'h0000, 1,16'h0005,0, 1,16'h0001, 0,16'h2222,0,0)); // pop, no push
    vecs.push_back(mkv(0,1,1,16'h0000, 0,16'h0000,0, 1,16'h0002, 0,16'h2222,1,0));
    vecs.push_back(mkv(0,1,1,16'h0000, 0,16'h0000,0, 1,16'h0003, 0,16'h2222,1,0));
    vecs.push_back(mkv(0,1,1,16'h0000, 0,16'h0000,0, 1,16'h0004, 0,16'h2222,1,0));
    vecs.push_back(mkv(0,1,1,16'h0000, 0,16'h0000,0, 1,16'h0000, 0,16'h2222,1,0)); // underflow
    vecs.push_back(mkv(0,1,2,16'h0000, 0,16'h0000,0, 1,16'h0011, 0,16'h2222,1,0));
    // Read while empty with a same-cycle push: returns 0, word still stored
    vecs.push_back(mkv(0,1,1,16'h0000, 1,16'h0077,0, 1,16'h0000, 0,16'h2222,1,0));
    vecs.push_back(mkv(0,1,1,16'h0000, 0,16'h0000,0, 1,16'h0077, 0,16'h2222,1,0));
    // Three buffered, push+pop keeps count, order preserved, flush beats push
    vecs.push_back(mkv(0,0,0,16'h0000, 1,16'h000A,0, 0,16'h0000, 0,16'h2222,1,0));
    vecs.push_back(mkv(0,0,0,16'h0000, 1,16'h000B,0, 0,16'h0000, 0,16'h2222,1,0));
    vecs.push_back(mkv(0,0,0,16'h0000, 1,16'h000C,0, 0,16'h0000, 0,16'h2222,1,0));
    vecs.push_back(mkv(0,1,1,16'h0000, 1,16'h000D,0, 1,16'h000A, 0,16'h2222,1,0));
    vecs.push_back(mkv(0,1,2,16'h0000, 0,16'h0000,0, 1,16'h0310, 0,16'h2222,1,0)); // count 3
    vecs.push_back(mkv(0,1,1,16'h0000, 0,16'h0000,0, 1,16'h000B, 0,16'h2222,1,0));
    vecs.push_back(mkv(0,1,1,16'h0000, 0,16'h0000,0, 1,16'h000C, 0,16'h2222,1,0));
    vecs.push_back(mkv(1,0,3,16'h0005, 1,16'h000F,0, 0,16'h0000, 0,16'h2222,1,0)); // flush+clear
    vecs.push_back(mkv(0,1,2,16'h0000, 0,16'h0000,0, 1,16'h0001, 0,16'h2222,1,0));
    // Write and read strobes together on IN: no drive, no pop
    vecs.push_back(mkv(0,0,0,16'h0000, 1,16'h0055,0, 0,16'h0000, 0,16'h2222,1,0));
    vecs.push_back(mkv(1,1,1,16'h9999, 0,16'h0000,0, 0,16'h0000, 0,16'h2222,1,0));
    vecs.push_back(mkv(0,1,2,16'h0000, 0,16'h0000,0, 1,16'h0100, 0,16'h2222,1,0));
    vecs.push_back(mkv(0,1,1,16'h0000, 0,16'h0000,0, 1,16'h0055, 0,16'h2222,1,0));
    vecs.push_back(mkv(0,1,2,16'h0000, 0,16'h0000,0, 1,16'h0001, 0,16'h2222,1,0));
    // CTRL readback and ignored STATUS write
    vecs.push_back(mkv(0,1,3,16'h0000, 0,16'h0000,0, 1,16'h0000, 0,16'h2222,1,0));
    vecs.push_back(mkv(1,0,2,16'hFFFF, 0,16'h0000,0, 0,16'h0000, 0,16'h2222,1,0));
    vecs.push_back(mkv(0,1,2,16'h0000, 0,16'h0000,0, 1,16'h0001, 0,16'h2222,1,0));

    reset = 1'b1;
    io_we = 1'b0; io_re = 1'b0; io_addr = 2'd0; tb_wd = 16'h0000;
    in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // irq: enable, push one word, irq rises one edge after count becomes 1,
    // falls one edge after the pop empties the FIFO
    run_vec(mkv(1,0,3,16'h0002, 0,16'h0000,0, 0,16'h0000, 0,16'h2222,1,0), "irq_en_wr");
    run_vec(mkv(0,0,0,16'h0000, 1,16'h0042,0, 0,16'h0000, 0,16'h2222,1,0), "irq_push");
    run_vec(mkv(0,1,2,16'h0000, 0,16'h0000,0, 1,IRQ_ON ? 16'h0120 : 16'h0100,
                0,16'h2222,1,0), "irq_status");
    run_vec(mkv(0,1,1,16'h0000, 0,16'h0000,0, 1,16'h0042, 0,16'h2222,1,IRQ_ON), "irq_pop");
    run_vec(mkv(0,1,3,16'h0000, 0,16'h0000,0, 1,IRQ_ON ? 16'h0002 : 16'h0000,
                0,16'h2222,1,IRQ_ON), "irq_ctrl_rd");
    run_vec(mkv(1,0,3,16'h0000, 0,16'h0000,0, 0,16'h0000, 0,16'h2222,1,0), "irq_low");
    run_vec(mkv(0,0,0,16'h0000, 0,16'h0000,0, 0,16'h0000, 0,16'h2222,1,0), "irq_off");

    // Reset in the middle of a handshake with a word buffered
    run_vec(mkv(1,0,0,16'hBEEF, 0,16'h0000,0, 0,16'h0000, 0,16'h2222,1,0), "rst_load");
    run_vec(mkv(0,0,0,16'h0000, 1,16'h0066,0, 0,16'h0000, 1,16'hBEEF,1,0), "rst_push");
    reset = 1'b1;
    run_vec(mkv(0,0,0,16'h0000, 0,16'h0000,0, 0,16'h0000, 1,16'hBEEF,1,0), "rst_assert");
    reset = 1'b0;
    run_vec(mkv(0,1,2,16'h0000, 0,16'h0000,0, 1,16'h0001, 0,16'h0000,1,0), "rst_status");
    run_vec(mkv(0,1,1,16'h0000, 0,16'h0000,0, 1,16'h0000, 0,16'h0000,1,0), "rst_in_rd");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
